// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcode encoding and execute-stage state types
package alu_pkg;

  localparam int ALUOP_W = 3;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_SLT  = 3'b100,
    ALU_XOR  = 3'b101,
    ALU_ILL6 = 3'b110,
    ALU_ILL7 = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } stage_state_e;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU: result, zero flag and illegal-opcode flag
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   src_a_i,
  input  logic [WIDTH-1:0]   src_b_i,
  input  logic [ALUOP_W-1:0] alu_control_i,
  output logic [WIDTH-1:0]   result_o,
  output logic               zero_o,
  output logic               illegal_o
);

  logic slt_w;

  assign slt_w = $signed(src_a_i) < $signed(src_b_i);

  always_comb begin
    result_o  = '0;
    illegal_o = 1'b0;
    case (alu_op_e'(alu_control_i))
      ALU_ADD: result_o = src_a_i + src_b_i;
      ALU_SUB: result_o = src_a_i - src_b_i;
      ALU_AND: result_o = src_a_i & src_b_i;
      ALU_OR:  result_o = src_a_i | src_b_i;
      ALU_SLT: result_o = {{(WIDTH-1){1'b0}}, slt_w};
      ALU_XOR: result_o = src_a_i ^ src_b_i;
      default: illegal_o = 1'b1;
    endcase
    zero_o = (result_o == '0);
  end

endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - ALU execute stage with two-entry skid buffer and saturating op counter
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic [ALUOP_W-1:0] alu_control,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               illegal,
  output logic [CNT_W-1:0]   op_count
);

  stage_state_e state_q, state_d;

  logic [WIDTH-1:0] core_res;
  logic             core_zero, core_ill;

  logic [WIDTH-1:0] main_res_q, skid_res_q;
  logic             main_zero_q, skid_zero_q;
  logic             main_ill_q, skid_ill_q;
  logic [CNT_W-1:0] cnt_q;

  logic acc, del;
  logic load_main_new, load_main_skid, load_skid;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .src_a_i       (src_a),
    .src_b_i       (src_b),
    .alu_control_i (alu_control),
    .result_o      (core_res),
    .zero_o        (core_zero),
    .illegal_o     (core_ill)
  );

  assign acc = in_valid && in_ready;
  assign del = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (acc) state_d = ST_ONE;
      ST_ONE: begin
        if (acc && !del)      state_d = ST_FULL;
        else if (!acc && del) state_d = ST_EMPTY;
      end
      ST_FULL:  if (del) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Handshake outputs decode only the state register, so in_ready never sees out_ready.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_EMPTY: in_ready = 1'b1;
      ST_ONE: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
      end
      ST_FULL:  out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  assign load_main_new  = acc && ((state_q == ST_EMPTY) || ((state_q == ST_ONE) && del));
  assign load_skid      = acc && (state_q == ST_ONE) && !del;
  assign load_main_skid = del && (state_q == ST_FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_res_q  <= '0;
      main_zero_q <= 1'b0;
      main_ill_q  <= 1'b0;
      skid_res_q  <= '0;
      skid_zero_q <= 1'b0;
      skid_ill_q  <= 1'b0;
    end else begin
      if (load_main_new) begin
        main_res_q  <= core_res;
        main_zero_q <= core_zero;
        main_ill_q  <= core_ill;
      end else if (load_main_skid) begin
        main_res_q  <= skid_res_q;
        main_zero_q <= skid_zero_q;
        main_ill_q  <= skid_ill_q;
      end
      if (load_skid) begin
        skid_res_q  <= core_res;
        skid_zero_q <= core_zero;
        skid_ill_q  <= core_ill;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     cnt_q <= '0;
    else if (del && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
  end

  assign result   = main_res_q;
  assign zero     = main_zero_q;
  assign illegal  = main_ill_q;
  assign op_count = cnt_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - randomized and directed self-checking bench for alu_exec_stage
module tb_alu_exec_stage;

  logic        clk;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] src_a, src_b, result;
  logic [2:0]  alu_control;
  logic        zero, illegal;
  logic [15:0] op_count;

  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [31:0] result4;
  logic        zero4, illegal4;
  logic [3:0]  op_count4;

  int n_vec = 0;
  int n_err = 0;

  logic [33:0] mq[$];
  int unsigned mcnt;

  logic        o_rdy, o_vld, o_zero, o_ill;
  logic [31:0] o_res;
  logic [15:0] o_cnt;
  logic        e_rdy, e_vld;
  logic [33:0] e_b;
  logic [15:0] e_cnt;

  alu_exec_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .src_a(src_a), .src_b(src_b), .alu_control(alu_control),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .illegal(illegal), .op_count(op_count)
  );

  alu_exec_stage #(.WIDTH(32), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .src_a(32'd9), .src_b(32'd2), .alu_control(3'b001),
    .out_valid(out_valid4), .out_ready(out_ready4), .result(result4),
    .zero(zero4), .illegal(illegal4), .op_count(op_count4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: {illegal, zero, result} from the opcode table using plain arithmetic.
  function automatic logic [33:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    logic [31:0] r;
    logic        ill;
    ill = 1'b0;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd5: r = a ^ b;
      default: begin r = 32'd0; ill = 1'b1; end
    endcase
    return {ill, (r == 32'd0), r};
  endfunction

  // Drives one cycle, samples the DUT mid-cycle and advances the FIFO model.
  task automatic apply(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic ordy);
    logic acc, del;
    @(negedge clk);
    in_valid = v; src_a = a; src_b = b; alu_control = op; out_ready = ordy;
    #1;
    o_rdy = in_ready; o_vld = out_valid; o_res = result;
    o_zero = zero; o_ill = illegal; o_cnt = op_count;
    e_rdy = (mq.size() < 2);
    e_vld = (mq.size() > 0);
    e_b   = e_vld ? mq[0] : 34'd0;
    e_cnt = 16'(mcnt);
    acc = v && e_rdy;
    del = e_vld && ordy;
    if (del) begin
      void'(mq.pop_front());
      if (mcnt < 65535) mcnt++;
    end
    if (acc) mq.push_back(ref_alu(a, b, op));
  endtask

  task automatic drain();
    apply(1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
    apply(1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_vec++; if (result !== 32'd0) begin n_err++; $display("FAIL reset_result: got %h expected 0", result); end
    n_vec++; if ({zero, illegal} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b expected 00", {zero, illegal}); end
    n_vec++; if (op_count !== 16'd0) begin n_err++; $display("FAIL reset_op_count: got %0d expected 0", op_count); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    mq.delete();
    mcnt = 0;
  endtask

  task automatic test_directed();
    logic [31:0] va[4]  = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'd1};
    logic [31:0] vb[4]  = '{32'd1, 32'd5, 32'd1, 32'hFFFFFFFF};
    logic [2:0]  vop[4] = '{3'd0, 3'd1, 3'd4, 3'd4};
    logic [31:0] vr[4]  = '{32'h80000000, 32'd0, 32'd1, 32'd0};
    logic        vz[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, va[i], vb[i], vop[i], 1'b1);
      apply(1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
      n_vec++; if (o_vld !== 1'b1) begin n_err++; $display("FAIL dir%0d_latency: out_valid %b expected 1", i, o_vld); end
      n_vec++; if (o_res !== vr[i]) begin n_err++; $display("FAIL dir%0d_result: got %h expected %h", i, o_res, vr[i]); end
      n_vec++; if (o_zero !== vz[i]) begin n_err++; $display("FAIL dir%0d_zero: got %b expected %b", i, o_zero, vz[i]); end
    end
  endtask

  task automatic test_illegal();
    logic [15:0] c0;
    drain();
    c0 = o_cnt;
    apply(1'b1, 32'd3, 32'd4, 3'b111, 1'b1);
    apply(1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
    n_vec++; if ({o_vld, o_ill, o_zero, o_res} !== {1'b1, 1'b1, 1'b1, 32'd0}) begin
      n_err++; $display("FAIL illegal_bundle: got v%b i%b z%b r%h expected v1 i1 z1 r0", o_vld, o_ill, o_zero, o_res);
    end
    apply(1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
    n_vec++; if (o_cnt !== 16'(c0 + 16'd1)) begin n_err++; $display("FAIL illegal_count: got %0d expected %0d", o_cnt, c0 + 16'd1); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a[3] = '{32'd10, 32'd20, 32'd30};
    logic [31:0] b[3] = '{32'd3, 32'd4, 32'd5};
    logic [15:0] c0;
    drain();
    c0 = o_cnt;
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, a[i], b[i], 3'd0, 1'b0);
      n_vec++; if (o_rdy !== (i < 2)) begin n_err++; $display("FAIL bp_in_ready%0d: got %b expected %b", i, o_rdy, i < 2); end
    end
    apply(1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
    n_vec++; if ({o_vld, o_res} !== {1'b1, 32'd13}) begin n_err++; $display("FAIL bp_first: got v%b r%0d expected v1 r13", o_vld, o_res); end
    apply(1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
    n_vec++; if ({o_vld, o_res} !== {1'b1, 32'd24}) begin n_err++; $display("FAIL bp_second: got v%b r%0d expected v1 r24", o_vld, o_res); end
    apply(1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
    n_vec++; if (o_vld !== 1'b0) begin n_err++; $display("FAIL bp_empty: out_valid %b expected 0", o_vld); end
    n_vec++; if (o_cnt !== 16'(c0 + 16'd2)) begin n_err++; $display("FAIL bp_count: got %0d expected %0d", o_cnt, c0 + 16'd2); end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      apply(($urandom_range(0, 3) != 0), a, b, 3'($urandom_range(0, 7)), ($urandom_range(0, 2) != 0));
      n_vec++; if (o_rdy !== e_rdy) begin n_err++; $display("FAIL rnd%0d_in_ready: got %b expected %b", i, o_rdy, e_rdy); end
      n_vec++; if (o_vld !== e_vld) begin n_err++; $display("FAIL rnd%0d_out_valid: got %b expected %b", i, o_vld, e_vld); end
      n_vec++; if (o_cnt !== e_cnt) begin n_err++; $display("FAIL rnd%0d_op_count: got %0d expected %0d", i, o_cnt, e_cnt); end
      if (e_vld) begin
        n_vec++;
        if ({o_ill, o_zero, o_res} !== e_b) begin
          n_err++; $display("FAIL rnd%0d_bundle: got %h expected %h", i, {o_ill, o_zero, o_res}, e_b);
        end
      end
    end
  endtask

  task automatic test_reset_full();
    drain();
    apply(1'b1, 32'd1, 32'd1, 3'd0, 1'b0);
    apply(1'b1, 32'd2, 32'd2, 3'd0, 1'b0);
    apply(1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
    n_vec++; if (o_rdy !== 1'b0) begin n_err++; $display("FAIL rf_full: in_ready %b expected 0", o_rdy); end
    #2 reset = 1'b1;
    #1;
    n_vec++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL rf_handshake: got %b expected 01", {out_valid, in_ready}); end
    n_vec++; if (op_count !== 16'd0) begin n_err++; $display("FAIL rf_op_count: got %0d expected 0", op_count); end
    @(negedge clk);
    reset = 1'b0;
    mq.delete();
    mcnt = 0;
    apply(1'b1, 32'hF0, 32'h0F, 3'd3, 1'b1);
    apply(1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
    n_vec++; if ({o_vld, o_res} !== {1'b1, 32'hFF}) begin n_err++; $display("FAIL rf_after: got v%b r%h expected v1 rff", o_vld, o_res); end
  endtask

  task automatic test_saturate();
    int exp;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      in_valid4  = (i < 17);
      out_ready4 = 1'b1;
      #1;
      exp = (i < 1) ? 0 : ((i - 1 > 15) ? 15 : i - 1);
      n_vec++;
      if (op_count4 !== 4'(exp)) begin n_err++; $display("FAIL sat%0d_op_count: got %0d expected %0d", i, op_count4, exp); end
    end
    @(negedge clk);
    in_valid4 = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    src_a = '0; src_b = '0; alu_control = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b0;
    mcnt = 0;
    test_reset();
    test_directed();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_full();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, the operand and result width in bits.
REQ-002 The module SHALL have parameter CNT_W, default 16, the completed-operation counter width in bits.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand/opcode bundle is valid this cycle.
REQ-006 in_ready  output  1  stage can accept a bundle this cycle.
REQ-007 src_a  input  WIDTH  first operand.
REQ-008 src_b  input  WIDTH  second operand (register or immediate, already muxed).
REQ-009 alu_control  input  3  operation code, same encoding the ALU decoder emits.
REQ-010 out_valid  output  1  result bundle is valid.
REQ-011 out_ready  input  1  downstream accepts the result bundle this cycle.
REQ-012 result  output  WIDTH  operation result.
REQ-013 zero  output  1  high when result is all zeros (branch compare flag).
REQ-014 illegal  output  1  high when the accepted alu_control was 110 or 111.
REQ-015 op_count  output  CNT_W  number of results handed downstream, saturating.

Function
REQ-016 Encoding SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT (signed), 101 XOR; 110/111 illegal.
REQ-017 ADD/SUB SHALL wrap modulo 2^WIDTH; no carry or overflow output.
REQ-018 SLT SHALL compare two's-complement operands and produce result 1 when src_a < src_b, else 0 (zero-extended).
REQ-019 Illegal codes SHALL produce result 0, zero=1, illegal=1 and SHALL still flow through the handshake.
REQ-020 A bundle SHALL transfer in when in_valid && in_ready and out when out_valid && out_ready.
REQ-021 The stage SHALL be a two-entry skid buffer (main + skid register); in_ready SHALL be a register output, never combinationally dependent on out_ready.
REQ-022 Latency from input transfer to out_valid SHALL be exactly 1 cycle when the stage is empty.
REQ-023 States: EMPTY (no entries), ONE (main full), FULL (main+skid full); in_ready=1 in EMPTY and ONE, 0 in FULL.
REQ-024 EMPTY->ONE on input transfer; ONE->EMPTY on output transfer without input; ONE stays ONE on simultaneous input and output transfer; ONE->FULL on input without output; FULL->ONE on output transfer (skid moves to main).
REQ-025 Results SHALL leave in acceptance order; no bundle SHALL be dropped or duplicated.
REQ-026 result/zero/illegal SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 op_count SHALL increment by 1 on each output transfer and saturate at 2^CNT_W-1.
REQ-028 Inputs SHALL be ignored when in_ready=0 regardless of in_valid.

Reset
REQ-029 Reset SHALL asynchronously force state EMPTY, in_ready=1, out_valid=0, result=0, zero=0, illegal=0, op_count=0.
REQ-030 Reset asserted mid-operation SHALL discard all buffered bundles; first bundle after deassertion SHALL see 1-cycle latency.

Structure
REQ-031 Package alu_pkg SHALL hold the ALU operation enum (3-bit codes above) and ALUOP width constant, shared with the ALU decoder.
REQ-032 Combinational computation SHALL live in sub-module alu_core (src_a, src_b, alu_control -> result, zero, illegal); alu_exec_stage SHALL hold only buffering, handshake, and counter.

Verification
REQ-033 ADD 0x7FFFFFFF+1, out_ready=1 -> next cycle out_valid=1, result=0x80000000, zero=0.
REQ-034 SUB 5-5 -> result=0, zero=1; SLT 0xFFFFFFFF,1 -> result=1; SLT 1,0xFFFFFFFF -> result=0.
REQ-035 out_ready=0, three back-to-back valid inputs -> two accepted, in_ready=0 from cycle 2; raise out_ready -> both results in order, op_count=2.
REQ-036 alu_control=111, src_a=3, src_b=4 -> result=0, zero=1, illegal=1, op_count increments.
REQ-037 Stage FULL, assert reset for one cycle -> out_valid=0, in_ready=1, op_count=0 immediately; next input emerges after 1 cycle.
REQ-038 CNT_W=4, 17 continuous transfers with out_ready=1 -> op_count stops at 15.
